// File: rtl/div_period_monitor.sv
// Per-channel rise strobe, period check and lock/fault tracking for the div2/div4/div6 divider outputs.
// state  | meaning
// IDLE   | disabled or waiting for the first rise; no measurement yet
// ARMED  | measuring periods, counting consecutive good ones toward lock
// LOCKED | LOCK_COUNT good periods seen; any bad period or timeout sets fault
module div_period_monitor #(
  parameter int EXP2       = 2,
  parameter int EXP4       = 4,
  parameter int EXP6       = 6,
  parameter int LOCK_COUNT = 4,
  parameter int CW         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clear_fault,
  input  logic       div2_i,
  input  logic       div4_i,
  input  logic       div6_i,
  output logic [2:0] rise,
  output logic [2:0] ch_locked,
  output logic       locked,
  output logic [2:0] fault
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [2:0] div;
  logic [2:0] prev;

  assign div    = {div6_i, div4_i, div2_i};
  assign locked = &ch_locked;

  // prev tracks the input even while disabled so the first rise after enable is genuine
  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= div;
  end

  for (genvar k = 0; k < 3; k++) begin : g_ch
    localparam logic [CW-1:0] EXP_K = (k == 0) ? CW'(EXP2) :
                                      (k == 1) ? CW'(EXP4) : CW'(EXP6);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    good;
    logic [3:0]    good_nxt;
    logic          locked_q;
    logic          fault_q;
    logic          meas_good;
    logic          meas_bad;

    assign rise[k]      = en & ~reset & div[k] & ~prev[k];
    assign good_nxt     = good + 4'd1;
    assign meas_good    = rise[k] & (cnt == EXP_K);
    // a saturated counter with no rise counts as a bad event every cycle
    assign meas_bad     = (rise[k] & (cnt != EXP_K)) | (~rise[k] & (cnt == CNT_MAX));
    assign ch_locked[k] = locked_q;
    assign fault[k]     = fault_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= IDLE;
        cnt      <= '0;
        good     <= '0;
        locked_q <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        if (clear_fault) fault_q <= 1'b0;
        if (!en) begin
          state    <= IDLE;
          cnt      <= '0;
          good     <= '0;
          locked_q <= 1'b0;
        end else begin
          if (rise[k])              cnt <= CW'(1);
          else if (cnt != CNT_MAX)  cnt <= cnt + CW'(1);
          case (state)
            IDLE: begin
              if (rise[k]) begin
                state <= ARMED;
                good  <= '0;
              end
            end
            ARMED: begin
              if (meas_good) begin
                good <= good_nxt;
                if (good_nxt == 4'(LOCK_COUNT)) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else if (meas_bad) begin
                good <= '0;
              end
            end
            LOCKED: begin
              // written after the clear so a coincident fault event wins
              if (meas_bad) begin
                state    <= ARMED;
                good     <= '0;
                locked_q <= 1'b0;
                fault_q  <= 1'b1;
              end
            end
            default: begin
              state    <= IDLE;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_div_period_monitor.sv
// Bench for div_period_monitor: timestamp-based reference model feeds a scoreboard queue,
// a negedge monitor pops and compares every cycle; directed scenarios then random traffic.
module tb_div_period_monitor;

  localparam int CMAX = 15;
  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset, en, clear_fault, div2_i, div4_i, div6_i;
  logic [2:0] rise, ch_locked, fault;
  logic       locked;

  always #5 clk = ~clk;

  div_period_monitor dut (
    .clk(clk), .reset(reset), .en(en), .clear_fault(clear_fault),
    .div2_i(div2_i), .div4_i(div4_i), .div6_i(div6_i),
    .rise(rise), .ch_locked(ch_locked), .locked(locked), .fault(fault)
  );

  typedef struct packed {
    logic [2:0] rise;
    logic [2:0] chl;
    logic       lk;
    logic [2:0] flt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: periods from rise timestamps
  int per_exp[3] = '{2, 4, 6};
  bit m_prev[3], m_armed[3], m_lock[3], m_fault[3];
  int m_run[3], m_last[3];
  int t = 0;

  // waveform generator state
  int ph[3];
  bit freeze[3];
  bit hold_lo[3];
  bit clr_on_rise2 = 1'b0;

  task automatic cyc(input bit e, input bit c, input bit r);
    bit [2:0] d;
    bit [2:0] rs;
    exp_t     x;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) d[k] = hold_lo[k] ? 1'b0 : (ph[k] < per_exp[k] / 2);
    if (clr_on_rise2 && e && !r && d[0] && !m_prev[0]) begin
      c = 1'b1;
      clr_on_rise2 = 1'b0;
    end
    reset = r; en = e; clear_fault = c;
    div2_i = d[0]; div4_i = d[1]; div6_i = d[2];
    for (int k = 0; k < 3; k++) begin
      rs[k]    = e & ~r & d[k] & ~m_prev[k];
      x.chl[k] = m_lock[k];
      x.flt[k] = m_fault[k];
    end
    x.rise = rs;
    x.lk   = &x.chl;
    sbq.push_back(x);
    for (int k = 0; k < 3; k++) begin
      bit good_ev, bad_ev, fs;
      good_ev = 1'b0; bad_ev = 1'b0; fs = 1'b0;
      if (r) begin
        m_armed[k] = 0; m_lock[k] = 0; m_run[k] = 0; m_fault[k] = 0;
      end else begin
        if (!e) begin
          m_armed[k] = 0; m_lock[k] = 0; m_run[k] = 0;
        end else if (!m_armed[k]) begin
          if (rs[k]) begin
            m_armed[k] = 1; m_run[k] = 0; m_last[k] = t;
          end
        end else begin
          if (rs[k]) begin
            good_ev   = ((t - m_last[k]) == per_exp[k]);
            bad_ev    = !good_ev;
            m_last[k] = t;
          end else if ((t - m_last[k]) >= CMAX) begin
            bad_ev = 1'b1;
          end
          if (bad_ev) begin
            m_run[k] = 0;
            if (m_lock[k]) begin
              m_lock[k] = 0;
              fs = 1'b1;
            end
          end else if (good_ev && !m_lock[k]) begin
            m_run[k]++;
            if (m_run[k] == LOCK) m_lock[k] = 1;
          end
        end
        if (c)  m_fault[k] = 0;
        if (fs) m_fault[k] = 1;
      end
      m_prev[k] = r ? 1'b0 : d[k];
      if (!freeze[k]) ph[k] = (ph[k] + 1) % per_exp[k];
      freeze[k] = 1'b0;
    end
    t++;
  endtask

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, req);
    end
  endtask

  task automatic glitch(input int k);
    while (ph[k] != 0) cyc(1, 0, 0);
    freeze[k] = 1'b1;
    cyc(1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_x = sbq.pop_front();
      n_checks++;
      if ({rise, ch_locked, locked, fault} !== mon_x) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got rise=%b chl=%b lk=%b flt=%b required rise=%b chl=%b lk=%b flt=%b",
                 $time, rise, ch_locked, locked, fault, mon_x.rise, mon_x.chl, mon_x.lk, mon_x.flt);
      end
    end
  end

  initial begin
    int en_off;
    int stall_n[3];
    bit e, c, r;
    reset = 1'b1; en = 1'b0; clear_fault = 1'b0;
    div2_i = 1'b0; div4_i = 1'b0; div6_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ph[k] = 0; freeze[k] = 0; hold_lo[k] = 0; stall_n[k] = 0;
      m_prev[k] = 0; m_armed[k] = 0; m_lock[k] = 0; m_fault[k] = 0; m_run[k] = 0; m_last[k] = 0;
    end
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("reset_outputs", {ch_locked[2:1], locked}, 3'b000);
    chk("reset_fault", fault, 3'b000);

    // ideal lock
    repeat (40) cyc(1, 0, 0);
    chk("ideal_locked", {2'b00, locked}, 3'b001);
    chk("ideal_fault", fault, 3'b000);

    // stretched div4 high phase
    glitch(1);
    repeat (30) cyc(1, 0, 0);
    chk("glitch_fault", fault, 3'b010);
    chk("glitch_relock", {2'b00, locked}, 3'b001);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    chk("clear_fault", fault, 3'b000);

    // div6 stall
    hold_lo[2] = 1'b1;
    repeat (20) cyc(1, 0, 0);
    hold_lo[2] = 1'b0;
    chk("stall_fault", fault, 3'b100);
    chk("stall_unlocked", ch_locked, 3'b011);
    repeat (40) cyc(1, 0, 0);

    // clear colliding with a bad div2 period, stale fault[1]
    glitch(1);
    repeat (30) cyc(1, 0, 0);
    glitch(0);
    clr_on_rise2 = 1'b1;
    repeat (6) cyc(1, 0, 0);
    chk("clear_collide", fault, 3'b001);

    // enable drop
    repeat (20) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("en_drop_unlocked", ch_locked, 3'b000);
    chk("en_drop_fault", fault, 3'b001);
    repeat (40) cyc(1, 0, 0);
    chk("en_relock", {2'b00, locked}, 3'b001);

    // all channels time out, then reset
    for (int k = 0; k < 3; k++) hold_lo[k] = 1'b1;
    repeat (18) cyc(1, 0, 0);
    for (int k = 0; k < 3; k++) hold_lo[k] = 1'b0;
    chk("all_fault", fault, 3'b111);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    chk("mid_reset_fault", fault, 3'b000);
    chk("mid_reset_locked", {ch_locked[1:0], locked}, 3'b000);

    // random traffic
    en_off = 0;
    repeat (700) begin
      e = 1'b1; c = 1'b0; r = 1'b0;
      if (en_off > 0) begin
        en_off--;
        e = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        en_off = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 29) == 0)  c = 1'b1;
      if ($urandom_range(0, 399) == 0) r = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 39) == 0) freeze[k] = 1'b1;
        if (stall_n[k] > 0) stall_n[k]--;
        else if ($urandom_range(0, 299) == 0) stall_n[k] = $urandom_range(8, 20);
        hold_lo[k] = (stall_n[k] > 0);
      end
      cyc(e, c, r);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
